keypad_entry_ctrl: RTL and testbench

Sequencing controller that sits downstream of the keypad scanner/decoder. It consumes the 4-bit decoded key code (4'hF = no key), qualifies each key into a single press event, and assembles two BCD operands. Each committed operand pair is delivered to the arithmetic/display datapath over a valid/ready handshake. It owns the operand-entry protocol; the scanner and the datapath stay stateless with respect to user entry.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/key_event_qualifier.sv | 96 +++++++++
 rtl/keypad_entry_ctrl.sv | 136 +++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad path: key code constants used by the
// scanner, the entry controller and the datapath, plus the state encodings
// of the entry controller and the key event qualifier.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_NONE    = 4'hF;  // no key pressed
  localparam logic [3:0] KEY_CLR_ALL = 4'hA;  // abandon both operands
  localparam logic [3:0] KEY_STAR    = 4'hD;  // clear the operand being typed
  localparam logic [3:0] KEY_HASH    = 4'hE;  // commit the operand being typed

  typedef enum logic [1:0] {
    ST_ENTRY_A  = 2'd0,
    ST_ENTRY_B  = 2'd1,
    ST_WAIT_ACK = 2'd2
  } ctrl_state_e;

  typedef enum logic {
    QS_ARMED = 1'b0,
    QS_HELD  = 1'b1
  } qual_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_event_qualifier.sv
// -----------------------------------------------------------------------------
// key_event_qualifier
// Turns the raw decoded key code into exactly one event per physical press.
// A code must be seen STABLE_CYCLES consecutive cycles to be accepted; the
// qualifier then waits for STABLE_CYCLES consecutive no-key cycles before it
// will accept another press.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   sample    in   decoded key code (4'hF = no key)
//   key_pulse out  one-cycle pulse per accepted press (registered)
//   key_code  out  code of the accepted press, valid with key_pulse
// -----------------------------------------------------------------------------
module key_event_qualifier
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sample,
  output logic       key_pulse,
  output logic [3:0] key_code
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  qual_state_e   state_q, state_d;
  logic [3:0]    prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic [3:0]    code_q, code_d;

  // prev_q resets to "no key" so a key held through reset release is seen
  // as a fresh change and must then stay stable for the full count.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= QS_ARMED;
      prev_q  <= KEY_NONE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      code_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      prev_q  <= sample;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      QS_ARMED: begin
        // The cycle a new code first appears counts as 1.
        if (sample == KEY_NONE)      cnt_d = '0;
        else if (sample == prev_q)   cnt_d = cnt_q + 1'b1;
        else                         cnt_d = CNT_ONE;
        if (cnt_d == CNT_MAX) begin
          state_d = QS_HELD;
          pulse_d = 1'b1;
          code_d  = sample;
          cnt_d   = '0;
        end
      end
      QS_HELD: begin
        // Only an uninterrupted run of no-key cycles re-arms; switching to
        // another code while held is swallowed.
        if (sample == KEY_NONE) cnt_d = cnt_q + 1'b1;
        else                    cnt_d = '0;
        if (cnt_d == CNT_MAX) begin
          state_d = QS_ARMED;
          cnt_d   = '0;
        end
      end
      default: state_d = QS_ARMED;
    endcase
  end

  always_comb begin
    key_pulse = pulse_q;
    key_code  = code_q;
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl
// Operand-entry controller between the keypad decoder and the arithmetic
// datapath. Qualified key presses build up two BCD operands; the committed
// pair is offered to the datapath with a valid/ready handshake.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   sample       in   decoded key code (0-9 digit, A clear-all, D '*',
//                     E '#', F no key, B/C unused)
//   op_ready     in   datapath accepts the operand pair
//   op_valid     out  operand pair available, held until accepted
//   operand_a    out  committed first operand, BCD, MS digit in MSBs
//   operand_b    out  committed second operand, BCD
//   entry        out  operand currently being typed
//   entry_sel    out  0 = typing A, 1 = typing B (or awaiting acceptance)
//   digit_count  out  number of digits in entry
// -----------------------------------------------------------------------------
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   sample,
  input  logic                         op_ready,
  output logic                         op_valid,
  output logic [4*DIGITS-1:0]          operand_a,
  output logic [4*DIGITS-1:0]          operand_b,
  output logic [4*DIGITS-1:0]          entry,
  output logic                         entry_sel,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count
);

  localparam int            W       = 4 * DIGITS;
  localparam int            CW      = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

  logic       key_pulse;
  logic [3:0] key_code;

  key_event_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qual (
    .clk      (clk),
    .reset    (reset),
    .sample   (sample),
    .key_pulse(key_pulse),
    .key_code (key_code)
  );

  ctrl_state_e   state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ENTRY_A;
      entry_q <= '0;
      count_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      ST_ENTRY_A, ST_ENTRY_B: begin
        if (key_pulse) begin
          if (is_digit(key_code)) begin
            // Shift left one BCD digit; a full entry drops further digits.
            if (count_q < DIG_MAX) begin
              entry_d      = entry_q << 4;
              entry_d[3:0] = key_code;
              count_d      = count_q + 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            entry_d = '0;
            count_d = '0;
          end else if (key_code == KEY_HASH) begin
            entry_d = '0;
            count_d = '0;
            if (state_q == ST_ENTRY_A) begin
              op_a_d  = entry_q;
              state_d = ST_ENTRY_B;
            end else begin
              op_b_d  = entry_q;
              state_d = ST_WAIT_ACK;
            end
          end else if (key_code == KEY_CLR_ALL) begin
            entry_d = '0;
            count_d = '0;
            state_d = ST_ENTRY_A;
          end
        end
      end
      ST_WAIT_ACK: begin
        // op_valid is high throughout this state, so op_ready alone marks
        // the transfer. Clear-all landing on the same cycle also ends in
        // ENTRY_A, so the two causes need no priority between them.
        if (op_ready || (key_pulse && key_code == KEY_CLR_ALL)) begin
          entry_d = '0;
          count_d = '0;
          state_d = ST_ENTRY_A;
        end
      end
      default: state_d = ST_ENTRY_A;
    endcase
  end

  always_comb begin
    op_valid    = (state_q == ST_WAIT_ACK);
    entry_sel   = (state_q != ST_ENTRY_A);
    operand_a   = op_a_q;
    operand_b   = op_b_q;
    entry       = entry_q;
    digit_count = count_q;
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int STABLE = 4;
  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int CW     = $clog2(DIGITS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    sample;
  logic          op_ready;
  logic          op_valid;
  logic [W-1:0]  operand_a, operand_b, entry;
  logic          entry_sel;
  logic [CW-1:0] digit_count;

  int checks = 0;
  int errors = 0;

  // Transfer monitor: counts accepted handshakes and captures the pair.
  int           xfer_cnt = 0;
  logic [W-1:0] cap_a = '0;
  logic [W-1:0] cap_b = '0;

  keypad_entry_ctrl #(
    .STABLE_CYCLES(STABLE),
    .DIGITS       (DIGITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .op_ready   (op_ready),
    .op_valid   (op_valid),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .entry      (entry),
    .entry_sel  (entry_sel),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && op_valid && op_ready) begin
      xfer_cnt = xfer_cnt + 1;
      cap_a    = operand_a;
      cap_b    = operand_b;
    end
  end

  // Inputs change and outputs are observed on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int rel);
    sample = key;
    cyc(hold);
    sample = KEY_NONE;
    cyc(rel);
  endtask

  task automatic tap(input logic [3:0] key);
    press(key, 10, 10);
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    sample   = KEY_NONE;
    op_ready = 1'b0;
    cyc(3);
    checks++;
    if ({op_valid, entry_sel, digit_count} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b sel=%b cnt=%0d expected 0 0 0", op_valid, entry_sel, digit_count);
    end
    checks++;
    if ({operand_a, operand_b, entry} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h e=%h expected all 0", operand_a, operand_b, entry);
    end
    reset = 1'b0;
    cyc(5);
    checks++;
    if (entry_sel !== 1'b0 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got sel=%b valid=%b expected 0 0", entry_sel, op_valid);
    end
  endtask

  task automatic test_basic_pair;
    int x0;
    x0 = xfer_cnt;
    op_ready = 1'b1;
    tap(4'd1); tap(4'd2); tap(4'd3);
    checks++;
    if (entry !== 12'h123 || digit_count !== 2'd3) begin
      errors++;
      $display("FAIL basic_entry_a: got %h/%0d expected 123/3", entry, digit_count);
    end
    tap(KEY_HASH);
    checks++;
    if (entry_sel !== 1'b1 || entry !== 12'h000 || operand_a !== 12'h123) begin
      errors++;
      $display("FAIL basic_commit_a: got sel=%b e=%h a=%h expected 1 000 123", entry_sel, entry, operand_a);
    end
    tap(4'd4); tap(4'd5); tap(KEY_HASH);
    checks++;
    if (xfer_cnt - x0 !== 1) begin
      errors++;
      $display("FAIL basic_xfer_count: got %0d expected 1", xfer_cnt - x0);
    end
    checks++;
    if (cap_a !== 12'h123 || cap_b !== 12'h045) begin
      errors++;
      $display("FAIL basic_operands: got a=%h b=%h expected 123 045", cap_a, cap_b);
    end
    checks++;
    if (entry_sel !== 1'b0 || op_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got sel=%b valid=%b expected 0 0", entry_sel, op_valid);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_overflow_and_star;
    tap(4'd9); tap(4'd8); tap(4'd7); tap(4'd6);
    checks++;
    if (entry !== 12'h987 || digit_count !== 2'd3) begin
      errors++;
      $display("FAIL overflow: got %h/%0d expected 987/3", entry, digit_count);
    end
    tap(KEY_STAR);
    checks++;
    if (entry !== 12'h000 || digit_count !== 2'd0 || entry_sel !== 1'b0) begin
      errors++;
      $display("FAIL star_clear: got %h/%0d sel=%b expected 000/0 0", entry, digit_count, entry_sel);
    end
  endtask

  task automatic test_qualifier;
    // One cycle short of the threshold: no event.
    press(4'd5, STABLE - 1, 10);
    checks++;
    if (entry !== 12'h000 || digit_count !== 2'd0) begin
      errors++;
      $display("FAIL short_press: got %h/%0d expected 000/0", entry, digit_count);
    end
    // Long press: exactly one event.
    press(4'd5, 1000, 10);
    checks++;
    if (entry !== 12'h005 || digit_count !== 2'd1) begin
      errors++;
      $display("FAIL long_press: got %h/%0d expected 005/1", entry, digit_count);
    end
    // Sliding from 3 to 4 without release: only the 3 counts.
    sample = 4'd3;
    cyc(10);
    press(4'd4, 10, 10);
    checks++;
    if (entry !== 12'h053 || digit_count !== 2'd2) begin
      errors++;
      $display("FAIL slide_no_release: got %h/%0d expected 053/2", entry, digit_count);
    end
    tap(KEY_STAR);
  endtask

  task automatic test_backpressure;
    int           x0;
    int           bad;
    logic [W-1:0] a0, b0;
    op_ready = 1'b0;
    x0 = xfer_cnt;
    tap(4'd1); tap(KEY_HASH); tap(4'd2); tap(KEY_HASH);
    a0 = operand_a;
    b0 = operand_b;
    checks++;
    if (op_valid !== 1'b1 || a0 !== 12'h001 || b0 !== 12'h002) begin
      errors++;
      $display("FAIL bp_commit: got valid=%b a=%h b=%h expected 1 001 002", op_valid, a0, b0);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      sample = (i < 10) ? 4'd7 : KEY_NONE;
      cyc(1);
      if (op_valid !== 1'b1 || operand_a !== a0 || operand_b !== b0 || entry !== 12'h000)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    end
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || entry_sel !== 1'b0 || xfer_cnt - x0 !== 1) begin
      errors++;
      $display("FAIL bp_transfer: got valid=%b sel=%b xfers=%0d expected 0 0 1", op_valid, entry_sel, xfer_cnt - x0);
    end
    checks++;
    if (cap_a !== 12'h001 || cap_b !== 12'h002 || entry !== 12'h000) begin
      errors++;
      $display("FAIL bp_data: got a=%h b=%h e=%h expected 001 002 000", cap_a, cap_b, entry);
    end
  endtask

  task automatic test_clear_all_wait_ack;
    int x0;
    op_ready = 1'b0;
    x0 = xfer_cnt;
    tap(4'd3); tap(KEY_HASH); tap(4'd4); tap(KEY_HASH);
    checks++;
    if (op_valid !== 1'b1 || entry_sel !== 1'b1) begin
      errors++;
      $display("FAIL ca_wait: got valid=%b sel=%b expected 1 1", op_valid, entry_sel);
    end
    tap(KEY_CLR_ALL);
    checks++;
    if (op_valid !== 1'b0 || entry_sel !== 1'b0 || entry !== 12'h000 || xfer_cnt != x0) begin
      errors++;
      $display("FAIL ca_drop: got valid=%b sel=%b e=%h xfers=%0d expected 0 0 000 0", op_valid, entry_sel, entry, xfer_cnt - x0);
    end
    checks++;
    if (operand_a !== 12'h003 || operand_b !== 12'h004) begin
      errors++;
      $display("FAIL ca_hold: got a=%h b=%h expected 003 004", operand_a, operand_b);
    end
  endtask

  task automatic test_reset_mid_entry;
    int x0;
    tap(4'd9); tap(KEY_HASH); tap(4'd4); tap(4'd2);
    checks++;
    if (entry !== 12'h042 || digit_count !== 2'd2 || entry_sel !== 1'b1) begin
      errors++;
      $display("FAIL mid_entry: got %h/%0d sel=%b expected 042/2 1", entry, digit_count, entry_sel);
    end
    sample = 4'd6;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({op_valid, entry_sel, digit_count} !== 4'b0 || {operand_a, operand_b, entry} !== 36'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b s=%b c=%0d a=%h b=%h e=%h expected all 0", op_valid, entry_sel, digit_count, operand_a, operand_b, entry);
    end
    @(negedge clk);
    reset = 1'b0;
    // Key 6 was held through reset: needs STABLE edges to pulse, plus one.
    cyc(STABLE);
    checks++;
    if (entry !== 12'h000) begin
      errors++;
      $display("FAIL held_through_early: got %h expected 000", entry);
    end
    cyc(1);
    checks++;
    if (entry !== 12'h006 || digit_count !== 2'd1) begin
      errors++;
      $display("FAIL held_through_accept: got %h/%0d expected 006/1", entry, digit_count);
    end
    sample = KEY_NONE;
    cyc(10);
    x0 = xfer_cnt;
    op_ready = 1'b1;
    tap(KEY_HASH); tap(4'd8); tap(KEY_HASH);
    op_ready = 1'b0;
    checks++;
    if (xfer_cnt - x0 !== 1 || cap_a !== 12'h006 || cap_b !== 12'h008) begin
      errors++;
      $display("FAIL post_reset_pair: got xfers=%0d a=%h b=%h expected 1 006 008", xfer_cnt - x0, cap_a, cap_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_overflow_and_star();
    test_qualifier();
    test_backpressure();
    test_clear_all_wait_ack();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
